dff_preset_clear: RTL and testbench



---
 rtl/dff_preset_clear_bit.sv | 25 ++
 rtl/dff_preset_clear.sv | 26 ++
 tb/tb_dff_preset_clear.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dff_preset_clear_bit.sv
// Single-bit D flip-flop with async active-low clear and preset; clear dominates.
// Replicated by dff_preset_clear to build a bank of bits.
module dff_bit (
    input  logic d,
    input  logic clk,
    input  logic preset,
    input  logic clear,
    output logic q
);

    // The set is qualified by clear. When clear is released while preset is
    // still low, set_n falls and retriggers the flop, so q goes high at that moment.
    logic set_n;
    assign set_n = preset | ~clear;

    always_ff @(posedge clk or negedge clear or negedge set_n) begin
        if (!clear)
            q <= 1'b0;
        else if (!set_n)
            q <= 1'b1;
        else
            q <= d;
    end

endmodule

// File: rtl/dff_preset_clear.sv
// WIDTH-bit bank of '74-style flip-flops: async clear beats async preset beats clk capture.
// qbar is the combinational complement of q, so the two outputs are never equal.
module dff_preset_clear #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             clk,
    input  logic             preset,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_bit u_bit (
            .d      (data[i]),
            .clk    (clk),
            .preset (preset),
            .clear  (clear),
            .q      (q[i])
        );
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_dff_preset_clear.sv
// Directed plus random-vector bench for dff_preset_clear, using a priority-rule reference model.
module tb_dff_preset_clear;
    localparam int W = 4;
    localparam logic [W-1:0] ONES = '1;
    localparam logic [W-1:0] ZERO = '0;

    logic [W-1:0] data;
    logic         tbclk, preset, clear;
    logic [W-1:0] q, qbar;

    dff_preset_clear #(.WIDTH(W)) dut (
        .data   (data),
        .clk    (tbclk),
        .preset (preset),
        .clear  (clear),
        .q      (q),
        .qbar   (qbar)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what q must be according to the priority rules.
    logic [W-1:0] mq;
    logic         pclk;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        if (!$isunknown(mq)) begin
            chk("model_q", q, mq);
            chk("model_qbar", qbar, ~mq);
        end
    endtask

    // Apply one input vector, update the model, sample 1 time unit later.
    task automatic step(input logic [W-1:0] d, input logic c, input logic p, input logic cl);
        if (!cl)
            mq = ZERO;
        else if (!p)
            mq = ONES;
        else if (!pclk && c)
            mq = d;
        pclk  = c;
        data  = d;
        tbclk = c;
        preset = p;
        clear  = cl;
        #1;
        compare_model();
        #4;
    endtask

    initial begin
        logic [W-1:0] rd;
        logic         rp, rc;
        mq = 'x;
        pclk = 1'b0;
        tbclk = 1'b0;
        data = ZERO;
        preset = 1'b1;
        clear = 1'b1;
        #5;

        // Async clear with clk held low, then release: no capture on release
        step(ONES, 1'b0, 1'b1, 1'b0);
        chk("clr_q", q, 4'h0);
        chk("clr_qbar", qbar, 4'hF);
        step(ONES, 1'b0, 1'b1, 1'b1);
        chk("clr_release_hold", q, 4'h0);
        step(ONES, 1'b1, 1'b1, 1'b1);
        chk("clr_then_capture", q, 4'hF);

        // Async preset; clk rise with preset low ignores data
        step(ZERO, 1'b0, 1'b1, 1'b1);
        step(ZERO, 1'b0, 1'b0, 1'b1);
        chk("preset_q", q, 4'hF);
        chk("preset_qbar", qbar, 4'h0);
        step(ZERO, 1'b1, 1'b0, 1'b1);
        chk("preset_clk_ignored", q, 4'hF);

        // Capture, data change while clk high, falling edge ignored
        step(4'h5, 1'b0, 1'b1, 1'b1);
        chk("preset_release_hold", q, 4'hF);
        step(4'h5, 1'b1, 1'b1, 1'b1);
        chk("capture_5", q, 4'h5);
        step(4'hA, 1'b1, 1'b1, 1'b1);
        chk("data_change_high", q, 4'h5);
        step(4'hA, 1'b0, 1'b1, 1'b1);
        chk("fall_ignored", q, 4'h5);
        step(4'hA, 1'b1, 1'b1, 1'b1);
        chk("capture_A", q, 4'hA);

        // Both asserted: clear wins; releasing clear alone lets preset take over
        step(4'h3, 1'b1, 1'b0, 1'b0);
        chk("both_q", q, 4'h0);
        chk("both_qbar", qbar, 4'hF);
        step(4'h3, 1'b1, 1'b0, 1'b1);
        chk("clear_rel_preset_low", q, 4'hF);
        step(4'h0, 1'b1, 1'b1, 1'b1);
        chk("preset_rel_no_edge", q, 4'hF);
        step(4'h0, 1'b0, 1'b1, 1'b1);
        step(4'h0, 1'b1, 1'b1, 1'b1);
        chk("capture_0", q, 4'h0);

        // clk rise during clear ignores data
        step(4'hF, 1'b0, 1'b1, 1'b0);
        step(4'hF, 1'b1, 1'b1, 1'b0);
        chk("clr_clk_ignored", q, 4'h0);
        step(4'hF, 1'b1, 1'b1, 1'b1);
        chk("clr_rel_high_clk", q, 4'h0);
        step(4'hF, 1'b0, 1'b1, 1'b1);
        step(4'hF, 1'b1, 1'b1, 1'b1);
        chk("capture_F", q, 4'hF);

        // Random vectors: change data/preset/clear, then toggle clk separately
        for (int i = 0; i < 1000; i++) begin
            rd = W'($urandom);
            rp = ($urandom_range(0, 7) != 0);
            rc = ($urandom_range(0, 9) != 0);
            step(rd, pclk, rp, rc);
            step(rd, ~pclk, rp, rc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
